mealy_seq_decoder: RTL and testbench

- Receiver-side inverse of the team's 3-state Mealy sequence encoder (S0/S1/S2, one encoded bit per clock).
- Tracks a mirror copy of the encoder state and recovers the original input bit from each encoded bit.
- Packs recovered bits LSB-first into WIDTH-bit words.
- Hands each word downstream over a valid/ready handshake.

---
 rtl/mealy_seq_pkg.sv | 32 +++
 rtl/mealy_seq_decoder_if.sv | 12 +
 rtl/mealy_dec_core.sv | 60 ++++++
 rtl/mealy_seq_decoder.sv | 124 ++++++++++++
 tb/tb_mealy_seq_decoder.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mealy_seq_pkg.sv
// rtl/mealy_seq_pkg.sv - shared state encodings and encoder step function for the Mealy sequence codec
package mealy_seq_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S0    = 2'b00,
    S1    = 2'b01,
    S2    = 2'b10,
    S_ILL = 2'b11
  } state_e;

  typedef struct packed {
    state_e next;
    logic   y;
  } enc_step_t;

  // Same table the encoder uses; the decoder replays it with the recovered bit.
  function automatic enc_step_t enc_step(input state_e s, input logic x);
    enc_step_t r;
    r.next = S0;
    r.y    = 1'b0;
    case (s)
      S0:      begin r.next = x ? S2 : S1; r.y = ~x;   end
      S1:      begin r.next = x ? S0 : S2; r.y = x;    end
      S2:      begin r.next = x ? S2 : S1; r.y = ~x;   end
      default: begin r.next = S0;          r.y = 1'b0; end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mealy_seq_decoder_if.sv
// rtl/mealy_seq_decoder_if.sv - recovered-word valid/ready stream
interface mealy_seq_decoder_if #(
  parameter int WIDTH = mealy_seq_pkg::DEFAULT_WIDTH
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_parity_err;

  modport master (output out_data, output out_valid, output out_parity_err, input out_ready);
  modport slave  (input out_data, input out_valid, input out_parity_err, output out_ready);
endinterface

// File: rtl/mealy_dec_core.sv
// rtl/mealy_dec_core.sv - per-bit inverse FSM tracking a mirror of the encoder state
module mealy_dec_core
  import mealy_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       sync,
  input  logic       code_in,
  input  logic       code_valid,
  output logic [1:0] state_reg,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       dec_bit,
  output logic       dec_take
);

  state_e    state_q, state_d;
  logic      bit_q, bit_d;
  logic      bv_q, bv_d;
  enc_step_t step;

  always_comb begin
    // Only S1 passes the input through; S0 and S2 emit its complement.
    dec_bit  = (state_q == S1) ? code_in : ~code_in;
    step     = enc_step(state_q, dec_bit);
    state_d  = state_q;
    bit_d    = bit_q;
    bv_d     = 1'b0;
    dec_take = 1'b0;
    if (sync) begin
      state_d = S0;
    end else if (code_valid) begin
      if (state_q == S_ILL) begin
        state_d = S0;
      end else begin
        state_d  = step.next;
        bit_d    = dec_bit;
        bv_d     = 1'b1;
        dec_take = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S0;
      bit_q   <= 1'b0;
      bv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      bv_q    <= bv_d;
    end
  end

  assign state_reg = state_q;
  assign bit_out   = bit_q;
  assign bit_valid = bv_q;

endmodule

// File: rtl/mealy_seq_decoder.sv
// rtl/mealy_seq_decoder.sv - Mealy sequence decoder with LSB-first word packing and valid/ready output
// Optional trailing even-parity bit per frame: MEALY_DEC_PARITY_EN.
module mealy_seq_decoder
  import mealy_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sync,
  input  logic                code_in,
  input  logic                code_valid,
  output logic                bit_out,
  output logic                bit_valid,
  output logic [1:0]          state_reg,
  output logic                overflow,
  mealy_seq_decoder_if.master out_if
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(WIDTH);

  logic             dec_bit, dec_take;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             ovf_q, ovf_d;
  logic             word_done;
  logic [WIDTH-1:0] word;
  logic             word_perr;

  mealy_dec_core u_core (
    .clk        (clk),
    .reset      (reset),
    .sync       (sync),
    .code_in    (code_in),
    .code_valid (code_valid),
    .state_reg  (state_reg),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .dec_bit    (dec_bit),
    .dec_take   (dec_take)
  );

  always_comb begin
    shift_d   = shift_q;
    count_d   = count_q;
    word_done = 1'b0;
    word      = shift_q;
    word_perr = 1'b0;
    if (sync) begin
      shift_d = '0;
      count_d = '0;
    end else if (dec_take) begin
`ifdef MEALY_DEC_PARITY_EN
      if (count_q == CW'(WIDTH)) begin
        word_done = 1'b1;
        word_perr = (^shift_q) != dec_bit;
        shift_d   = '0;
        count_d   = '0;
      end else begin
        shift_d[count_q[IW-1:0]] = dec_bit;
        count_d                  = count_q + CW'(1);
      end
`else
      word[count_q[IW-1:0]]    = dec_bit;
      shift_d[count_q[IW-1:0]] = dec_bit;
      if (count_q == CW'(WIDTH - 1)) begin
        word_done = 1'b1;
        shift_d   = '0;
        count_d   = '0;
      end else begin
        count_d = count_q + CW'(1);
      end
`endif
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ovf_d   = ovf_q;
    if (valid_q && out_if.out_ready) begin
      valid_d = 1'b0;
    end
    // A completed word may replace the one being consumed on the same edge.
    if (word_done) begin
      if (!valid_q || out_if.out_ready) begin
        data_d  = word;
        perr_d  = word_perr;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      count_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      count_q <= count_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_if.out_data       = data_q;
  assign out_if.out_valid      = valid_q;
  assign out_if.out_parity_err = perr_q;
  assign overflow              = ovf_q;

endmodule

// File: tb/tb_mealy_seq_decoder.sv
// tb/tb_mealy_seq_decoder.sv - scoreboard bench for mealy_seq_decoder
module tb_mealy_seq_decoder;
  import mealy_seq_pkg::*;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sync = 1'b0;
  logic       code_in = 1'b0;
  logic       code_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       bit_out, bit_valid, overflow;
  logic [1:0] state_reg;

  int total = 0;
  int bad = 0;

  logic       exp_bits[$];
  logic [8:0] exp_words[$];
  logic [1:0] enc_st = 2'b00;

  mealy_seq_decoder_if #(.WIDTH(W)) oif ();
  assign oif.out_ready = out_ready;

  mealy_seq_decoder #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .sync       (sync),
    .code_in    (code_in),
    .code_valid (code_valid),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .state_reg  (state_reg),
    .overflow   (overflow),
    .out_if     (oif)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference encoder table: returns {next_state, y}.
  function automatic logic [2:0] enc(input logic [1:0] s, input logic x);
    case (s)
      2'b00:   enc = x ? {2'b10, 1'b0} : {2'b01, 1'b1};
      2'b01:   enc = x ? {2'b00, 1'b1} : {2'b10, 1'b0};
      2'b10:   enc = x ? {2'b10, 1'b0} : {2'b01, 1'b1};
      default: enc = 3'b000;
    endcase
  endfunction

  // Monitor: bit scoreboard and word scoreboard, sampled on the falling edge.
  initial begin
    logic       eb;
    logic [8:0] ew;
    forever begin
      @(negedge clk);
      if (bit_valid) begin
        if (exp_bits.size() == 0) begin
          check("unexpected_bit_valid", 32'(bit_valid), 32'(0));
        end else begin
          eb = exp_bits.pop_front();
          check("bit_out", 32'(bit_out), 32'(eb));
        end
      end
      if (oif.out_valid && out_ready) begin
        if (exp_words.size() == 0) begin
          check("unexpected_word", 32'(oif.out_data), 32'hdead);
        end else begin
          ew = exp_words.pop_front();
          check("out_data", 32'(oif.out_data), 32'(ew[7:0]));
          check("out_parity_err", 32'(oif.out_parity_err), 32'(ew[8]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b1;
    #2;
    check("rst_state", 32'(state_reg), 32'(0));
    check("rst_bit_out", 32'(bit_out), 32'(0));
    check("rst_bit_valid", 32'(bit_valid), 32'(0));
    check("rst_out_valid", 32'(oif.out_valid), 32'(0));
    check("rst_out_data", 32'(oif.out_data), 32'(0));
    check("rst_perr", 32'(oif.out_parity_err), 32'(0));
    check("rst_overflow", 32'(overflow), 32'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    enc_st = 2'b00;
  endtask

  task automatic send_code(input logic c, input logic x_exp, input logic push);
    code_in = c;
    code_valid = 1'b1;
    if (push) exp_bits.push_back(x_exp);
    @(posedge clk);
    #1;
    code_valid = 1'b0;
  endtask

  task automatic send_bit(input logic x);
    logic [2:0] r;
    r = enc(enc_st, x);
    send_code(r[0], x, 1'b1);
    enc_st = r[2:1];
  endtask

  task automatic send_bits(input logic [7:0] d, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_bit(d[i]);
  endtask

  task automatic send_word(input logic [7:0] d, input logic flip, input logic expect_word);
`ifdef MEALY_DEC_PARITY_EN
    if (expect_word) exp_words.push_back({flip, d});
    send_bits(d, 0, 7);
    send_bit((^d) ^ flip);
`else
    if (expect_word) exp_words.push_back({1'b0, d});
    send_bits(d, 0, 7);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [7:0] codes;
    logic [7:0] xs;
    codes = 8'h24;
    xs    = 8'h93;
    #1;
    do_reset();

    // Hand-computed stream from S0.
    out_ready = 1'b1;
    exp_words.push_back({1'b0, 8'h93});
    for (int i = 0; i < 8; i++) send_code(codes[i], xs[i], 1'b1);
    enc_st = 2'b10;
`ifdef MEALY_DEC_PARITY_EN
    send_bit(1'b0);
`else
    check("t1_state_s2", 32'(state_reg), 32'(2'b10));
`endif
    check("t1_out_valid", 32'(oif.out_valid), 32'(1));
    check("t1_state", 32'(state_reg), 32'(enc_st));
    idle(1);
    check("t1_out_valid_pulse", 32'(oif.out_valid), 32'(0));

    // Backpressure: second word dropped, first held.
    out_ready = 1'b0;
    send_word(8'h93, 1'b0, 1'b1);
    send_word(8'h93, 1'b0, 1'b0);
    check("t2_overflow", 32'(overflow), 32'(1));
    check("t2_held_valid", 32'(oif.out_valid), 32'(1));
    check("t2_held_data", 32'(oif.out_data), 32'h93);
    out_ready = 1'b1;
    idle(1);
    check("t2_drained", 32'(oif.out_valid), 32'(0));
    check("t2_overflow_sticky", 32'(overflow), 32'(1));
    do_reset();

    // Stall mid-word.
    out_ready = 1'b1;
    exp_words.push_back({1'b0, 8'h93});
    send_bits(8'h93, 0, 3);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("t3_state_frozen", 32'(state_reg), 32'(enc_st));
    end
    send_bits(8'h93, 4, 7);
`ifdef MEALY_DEC_PARITY_EN
    send_bit(1'b0);
`endif
    idle(2);

    // sync after 4 bits discards the partial word and the coincident bit.
    send_bits(8'h93, 0, 3);
    check("t4_pre_sync_state", 32'(state_reg), 32'(2'b10));
    sync = 1'b1;
    code_valid = 1'b1;
    code_in = 1'b0;
    @(posedge clk);
    #1;
    sync = 1'b0;
    code_valid = 1'b0;
    enc_st = 2'b00;
    check("t4_sync_state", 32'(state_reg), 32'(0));
    check("t4_sync_no_bit", 32'(bit_valid), 32'(0));
    send_word(8'hA5, 1'b0, 1'b1);
    idle(2);

    // Reset mid-word.
    send_bits(8'h5A, 0, 2);
    idle(1);
    do_reset();
    send_word(8'h3C, 1'b0, 1'b1);
    idle(2);

    // Illegal mirror state recovers to S0 without emitting a bit.
    do_reset();
    @(negedge clk);
    force dut.u_core.state_q = S_ILL;
    #1;
    release dut.u_core.state_q;
    @(posedge clk);
    #1;
    check("t5_illegal_held", 32'(state_reg), 32'(2'b11));
    send_code(1'b1, 1'b0, 1'b0);
    check("t5_recover_s0", 32'(state_reg), 32'(0));
    check("t5_no_bit", 32'(bit_valid), 32'(0));
    send_word(8'hC3, 1'b0, 1'b1);
    idle(2);

    // Extreme data patterns, plus parity error injection when enabled.
    send_word(8'h00, 1'b0, 1'b1);
    send_word(8'hFF, 1'b0, 1'b1);
    send_word(8'h01, 1'b0, 1'b1);
`ifdef MEALY_DEC_PARITY_EN
    send_word(8'h93, 1'b0, 1'b1);
    send_word(8'h93, 1'b1, 1'b1);
`endif
    idle(3);

    check("words_left", 32'(exp_words.size()), 32'(0));
    check("bits_left", 32'(exp_bits.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
